oled_spi_receiver: RTL

- Receive side of the 4-wire SSD1306-style OLED SPI link (sclk, sdin, cs, dc, reset), i.e. the display end of what the screen driver transmits.
- Deserialises bytes MSB-first on sclk rising edges while cs is low and tags each byte as command (dc=0) or data (dc=1).
- Decodes the SSD1306 command subset the driver uses and writes data bytes into a 1024-byte framebuffer through a write port.
- Serves as a loopback/emulation target for board self-test and simulation.

---
 rtl/oled_pkg.sv | 40 ++++
 rtl/spi_byte_deser.sv | 122 ++++++++++++
 rtl/oled_spi_receiver.sv | 134 +++++++++++++
 3 files changed

// File: rtl/oled_pkg.sv
// Shared constants, decoder state type and opcode helpers for the OLED SPI receiver.
package oled_pkg;

  // SSD1306 opcodes that change receiver state
  localparam logic [7:0] OP_DISPLAY_OFF = 8'hAE;
  localparam logic [7:0] OP_DISPLAY_ON  = 8'hAF;
  localparam logic [7:0] OP_CONTRAST    = 8'h81;
  localparam logic [7:0] OP_ADDR_MODE   = 8'h20;
  localparam logic [7:0] OP_CHARGE_PUMP = 8'h8D;
  localparam logic [7:0] OP_COL_ADDR    = 8'h21;
  localparam logic [7:0] OP_PAGE_ADDR   = 8'h22;
  localparam logic [7:0] OP_PAGE_BASE   = 8'hB0;

  // Single-argument opcodes whose argument is consumed but ignored
  localparam logic [7:0] OP_MUX_RATIO   = 8'hA8;
  localparam logic [7:0] OP_DISP_OFFSET = 8'hD3;
  localparam logic [7:0] OP_CLK_DIV     = 8'hD5;
  localparam logic [7:0] OP_PRECHARGE   = 8'hD9;
  localparam logic [7:0] OP_VCOMH       = 8'hDB;

  // Reset defaults
  localparam logic [7:0] CONTRAST_RST  = 8'h7F;
  localparam logic [1:0] ADDR_MODE_RST = 2'b10;

  typedef enum logic [1:0] {
    CMD_IDLE,
    CMD_ARG,
    CMD_ARG2A,
    CMD_ARG2B
  } cmd_state_e;

  // True for opcodes followed by exactly one argument byte
  function automatic logic takes_one_arg(input logic [7:0] op);
    return (op == OP_CONTRAST)   || (op == OP_ADDR_MODE)   ||
           (op == OP_MUX_RATIO)  || (op == OP_DISP_OFFSET) ||
           (op == OP_CLK_DIV)    || (op == OP_PRECHARGE)   ||
           (op == OP_VCOMH)      || (op == OP_CHARGE_PUMP);
  endfunction

endpackage

// File: rtl/spi_byte_deser.sv
// Input synchroniser, sclk edge detect and MSB-first byte deserialiser.
module spi_byte_deser
  import oled_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       io_sclk_i,
  input  logic       io_sdin_i,
  input  logic       io_cs_i,
  input  logic       io_dc_i,
  input  logic       io_reset_i,
  output logic       rst_int_o,
  output logic       byte_valid_o,
  output logic [7:0] byte_o,
  output logic       byte_is_data_o,
  output logic       frame_err_o
);

  logic [3:0] in_raw;
  logic [3:0] in_s;
  logic       sclk_s, sdin_s, cs_s, dc_s, nreset_s;

  assign in_raw = {io_reset_i, io_dc_i, io_cs_i, io_sclk_i};

  if (SYNC_STAGES == 0) begin : g_nosync
    assign in_s = {in_raw[3:2], in_raw[1], in_raw[0]};
  end else begin : g_sync
    logic [SYNC_STAGES-1:0][3:0] sync_q;
    // Synchroniser chain; idles at the bus idle level (all ones)
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        sync_q <= '1;
      end else begin
        sync_q[0] <= in_raw;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
          sync_q[i] <= sync_q[i-1];
        end
      end
    end
    assign in_s = sync_q[SYNC_STAGES-1];
  end

  // sdin is sampled only on a detected rising edge, so it shares the chain via a separate flop path
  logic sdin_pipe;
  if (SYNC_STAGES == 0) begin : g_sdin_direct
    assign sdin_pipe = io_sdin_i;
  end else begin : g_sdin_sync
    logic [SYNC_STAGES-1:0] sdin_q;
    // Data-line synchroniser, same depth as the control lines
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        sdin_q <= '0;
      end else begin
        sdin_q[0] <= io_sdin_i;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
          sdin_q[i] <= sdin_q[i-1];
        end
      end
    end
    assign sdin_pipe = sdin_q[SYNC_STAGES-1];
  end

  assign sclk_s   = in_s[0];
  assign cs_s     = in_s[1];
  assign dc_s     = in_s[2];
  assign nreset_s = in_s[3];
  assign sdin_s   = sdin_pipe;

  assign rst_int_o = reset_i | ~nreset_s;

  logic       sclk_prev_q;
  logic       sclk_rise;
  logic [2:0] cnt_q;
  logic [6:0] shift_q;
  logic       valid_q, dc_q, ferr_q;
  logic [7:0] byte_q;

  assign sclk_rise = sclk_s & ~sclk_prev_q;

  // Previous sclk level; tracks the line even during display reset so release never fakes an edge
  always_ff @(posedge clk_i) begin
    if (reset_i) sclk_prev_q <= 1'b1;
    else         sclk_prev_q <= sclk_s;
  end

  // Bit counter, shift register and byte/frame-error pulses
  always_ff @(posedge clk_i) begin
    if (rst_int_o) begin
      cnt_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      byte_q  <= '0;
      dc_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      if (cs_s) begin
        if (cnt_q != 3'd0) ferr_q <= 1'b1;
        cnt_q <= '0;
      end else if (sclk_rise) begin
        shift_q <= {shift_q[5:0], sdin_s};
        if (cnt_q == 3'd7) begin
          valid_q <= 1'b1;
          byte_q  <= {shift_q, sdin_s};
          dc_q    <= dc_s;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + 3'd1;
        end
      end
    end
  end

  assign byte_valid_o   = valid_q;
  assign byte_o         = byte_q;
  assign byte_is_data_o = dc_q;
  assign frame_err_o    = ferr_q;

endmodule

// File: rtl/oled_spi_receiver.sv
// SSD1306-style SPI receiver: command decoder, config registers and framebuffer write port.
module oled_spi_receiver
  import oled_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FB_DEPTH    = 1024
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       io_sclk_i,
  input  logic       io_sdin_i,
  input  logic       io_cs_i,
  input  logic       io_dc_i,
  input  logic       io_reset_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_o,
  output logic       byte_is_data_o,
  output logic       fb_we_o,
  output logic [9:0] fb_addr_o,
  output logic [7:0] fb_data_o,
  output logic       display_on_o,
  output logic [7:0] contrast_o,
  output logic [1:0] addr_mode_o,
  output logic       charge_pump_o,
  output logic       frame_err_o
);

  localparam logic [9:0] PTR_LAST = 10'(FB_DEPTH - 1);

  logic       rst_int;
  logic       valid_w, is_data_w;
  logic [7:0] byte_w;

  spi_byte_deser #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_deser (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .io_sclk_i      (io_sclk_i),
    .io_sdin_i      (io_sdin_i),
    .io_cs_i        (io_cs_i),
    .io_dc_i        (io_dc_i),
    .io_reset_i     (io_reset_i),
    .rst_int_o      (rst_int),
    .byte_valid_o   (valid_w),
    .byte_o         (byte_w),
    .byte_is_data_o (is_data_w),
    .frame_err_o    (frame_err_o)
  );

  cmd_state_e state_q, state_d;
  logic [7:0] op_q, op_d;
  logic [9:0] ptr_q, ptr_d;
  logic       disp_q, disp_d;
  logic [7:0] contrast_q, contrast_d;
  logic [1:0] mode_q, mode_d;
  logic       cp_q, cp_d;

  // Decoder state and configuration registers
  always_ff @(posedge clk_i) begin
    if (rst_int) begin
      state_q    <= CMD_IDLE;
      op_q       <= '0;
      ptr_q      <= '0;
      disp_q     <= 1'b0;
      contrast_q <= CONTRAST_RST;
      mode_q     <= ADDR_MODE_RST;
      cp_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      ptr_q      <= ptr_d;
      disp_q     <= disp_d;
      contrast_q <= contrast_d;
      mode_q     <= mode_d;
      cp_q       <= cp_d;
    end
  end

  // Next-state: data bytes advance the pointer, command bytes walk the decoder
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    ptr_d      = ptr_q;
    disp_d     = disp_q;
    contrast_d = contrast_q;
    mode_d     = mode_q;
    cp_d       = cp_q;
    if (valid_w) begin
      if (is_data_w) begin
        ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + 10'd1;
        if (state_q == CMD_ARG) state_d = CMD_IDLE;
      end else begin
        unique case (state_q)
          CMD_IDLE: begin
            if (byte_w == OP_DISPLAY_OFF) begin
              disp_d = 1'b0;
            end else if (byte_w == OP_DISPLAY_ON) begin
              disp_d = 1'b1;
            end else if (takes_one_arg(byte_w)) begin
              op_d    = byte_w;
              state_d = CMD_ARG;
            end else if ((byte_w == OP_COL_ADDR) || (byte_w == OP_PAGE_ADDR)) begin
              state_d = CMD_ARG2A;
            end else if (byte_w[7:3] == OP_PAGE_BASE[7:3]) begin
              ptr_d = {byte_w[2:0], 7'd0};
            end
          end
          CMD_ARG: begin
            if (op_q == OP_CONTRAST)    contrast_d = byte_w;
            if (op_q == OP_ADDR_MODE)   mode_d     = byte_w[1:0];
            if (op_q == OP_CHARGE_PUMP) cp_d       = byte_w[2];
            state_d = CMD_IDLE;
          end
          CMD_ARG2A: state_d = CMD_ARG2B;
          CMD_ARG2B: state_d = CMD_IDLE;
          default:   state_d = CMD_IDLE;
        endcase
      end
    end
  end

  assign byte_valid_o   = valid_w;
  assign byte_o         = byte_w;
  assign byte_is_data_o = is_data_w;
  assign fb_we_o        = valid_w & is_data_w;
  assign fb_addr_o      = ptr_q;
  assign fb_data_o      = byte_w;
  assign display_on_o   = disp_q;
  assign contrast_o     = contrast_q;
  assign addr_mode_o    = mode_q;
  assign charge_pump_o  = cp_q;

endmodule
